// File: rtl/schoolbook_mac_ctrl_if.sv
// Bus between the polynomial engine (master) and the MAC sequencer (slave).
interface schoolbook_mac_ctrl_if;
  localparam int unsigned N_COEF = 256;
  localparam int unsigned A_W    = 13;
  localparam int unsigned S_W    = 4;

  logic                      start;
  logic                      acc_clr;
  logic [N_COEF*A_W-1:0]     a_poly;
  logic [N_COEF*S_W-1:0]     s_poly;
  logic                      busy;
  logic                      done;
  logic [N_COEF*A_W-1:0]     result;

  modport master (
    output start, acc_clr, a_poly, s_poly,
    input  busy, done, result
  );

  modport slave (
    input  start, acc_clr, a_poly, s_poly,
    output busy, done, result
  );
endinterface

// File: rtl/schoolbook_mac_ctrl.sv
// Schoolbook negacyclic multiply-accumulate sequencer with its 256-lane MAC array.

// 256 parallel lanes: acc_o[j] = acc_i[j] + sext(s_i[j]) * a_coeff_i, mod 2^13.
module schoolbook_mac_array (
  input  logic [3327:0] acc_i,
  input  logic [1023:0] s_i,
  input  logic [12:0]   a_coeff_i,
  output logic [3327:0] acc_o
);
  localparam int unsigned N_COEF = 256;
  localparam int unsigned A_W    = 13;
  localparam int unsigned S_W    = 4;

  for (genvar j = 0; j < N_COEF; j++) begin : g_lane
    logic [S_W-1:0] s_lane;
    logic [A_W-1:0] s_ext;
    assign s_lane = s_i[j*S_W +: S_W];
    assign s_ext  = {{(A_W-S_W){s_lane[S_W-1]}}, s_lane};
    // Low 13 bits of the product are identical for signed and unsigned operands.
    assign acc_o[j*A_W +: A_W] = acc_i[j*A_W +: A_W] + A_W'(s_ext * a_coeff_i);
  end
endmodule

module schoolbook_mac_ctrl (
  input logic                   clk,
  input logic                   rst,
  schoolbook_mac_ctrl_if.slave  bus
);
  localparam int unsigned N_COEF = 256;
  localparam int unsigned A_W    = 13;
  localparam int unsigned S_W    = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned A_BITS = N_COEF * A_W;
  localparam int unsigned S_BITS = N_COEF * S_W;

  typedef enum logic {IDLE, RUN} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    i_q, i_d;
  logic [A_BITS-1:0]   a_q, a_d;
  logic [S_BITS-1:0]   s_q, s_d;
  logic [A_BITS-1:0]   result_q, result_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [A_BITS-1:0]   mac_out;
  logic [S_W-1:0]      s_top;
  logic [S_W-1:0]      s_top_neg;

  assign s_top     = s_q[S_BITS-1 -: S_W];
  assign s_top_neg = ~s_top + S_W'(1);

  schoolbook_mac_array u_mac (
    .acc_i     (result_q),
    .s_i       (s_q),
    .a_coeff_i (a_q[A_W-1:0]),
    .acc_o     (mac_out)
  );

  // State and datapath registers; reset discards any partial product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      i_q      <= '0;
      a_q      <= '0;
      s_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      a_q      <= a_d;
      s_q      <= s_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state: latch operands on start, then 256 MAC steps with A shift and negacyclic S rotate.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    a_d      = a_q;
    s_d      = s_q;
    result_d = result_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a_poly;
          s_d     = bus.s_poly;
          i_d     = '0;
          state_d = RUN;
          if (bus.acc_clr) begin
            result_d = '0;
          end
        end
      end
      RUN: begin
        result_d = mac_out;
        a_d      = {A_W'(0), a_q[A_BITS-1:A_W]};
        s_d      = {s_q[S_BITS-S_W-1:0], s_top_neg};
        i_d      = i_q + CNT_W'(1);
        if (i_q == CNT_W'(N_COEF - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: doc/schoolbook_mac_ctrl.md
# schoolbook_mac_ctrl

Sequencer for the 256-lane parallel MAC array in the schoolbook polynomial multiplier. It computes one negacyclic product acc' = acc + a(x)·s(x) mod (x^256 + 1, 2^13). The block latches a full 13-bit polynomial and a 4-bit secret polynomial on `start`, then streams one `a` coefficient per cycle for 256 cycles while rotating the secret. It sits between the top-level polynomial engine and the MAC array, which it instantiates internally.

## Interface
- Parameters: none. The array is fixed at 256 coefficients, with 13-bit accumulator lanes and 4-bit secret lanes.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a multiplication; sampled only in IDLE.
- `acc_clr`  in  1  sampled with `start`. 1 = accumulator starts at 0; 0 = accumulate onto the current `result`.
- `a_poly`  in  3328  coefficient k at bits [13k+12:13k], unsigned mod 2^13; sampled with `start`.
- `s_poly`  in  1024  coefficient k at bits [4k+3:4k], 4-bit two's complement; sampled with `start`.
- `busy`  out  1  high while iterating.
- `done`  out  1  one-cycle pulse when `result` becomes final.
- `result`  out  3328  accumulator register, same packing as `a_poly`; holds its value in IDLE.

## Operation
- MAC lane contract, per lane j: out_j = (acc_j + sext(s_j)·a_coeff) mod 2^13.
- All 256 lanes share one `a_coeff` per cycle.
- States are IDLE and RUN, plus an 8-bit iteration counter `i`.
- IDLE with `start`=1, on the clock edge:
  - `a_poly` is loaded into shift register A.
  - `s_poly` is loaded into rotate register S.
  - `result` is cleared to 0 if `acc_clr`=1, otherwise kept.
  - `i` is set to 0 and the state moves to RUN.
- RUN, on each edge:
  - `result` <= MAC(`result`, S, A[12:0]).
  - A shifts right by 13 bits, with zero fill.
  - S rotates negacyclically: S'_0 = −S_255 (4-bit two's complement negation), and S'_k = S_{k−1} for k ≥ 1.
  - `i` increments.
- RUN exit: on the edge where `i` = 255 is consumed, the state returns to IDLE and `done` is set for one cycle.
- Resulting math, for iteration i: lane k receives a_i·s_{k−i} for k ≥ i, and −a_i·s_{k−i+256} for k < i.
- Secret range: coefficients must lie in [−7, 7]. A value of −8 negates to −8, which is defined wrap behaviour and not an error.
- `start` while `busy` is ignored and has no effect.
- `acc_clr`, `a_poly` and `s_poly` are don't-care outside the `start` edge.
- `result` is only modified in RUN or by the IDLE clear. It is stable from `done` until the next accepted `start`.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0; `result`=0; A=0, S=0, `i`=0.
- Edge numbering: let E0 be the edge accepting `start`.
  - `busy`=1 from after E0 through E256.
  - MAC updates happen on E1..E256.
  - `done`=1 during the cycle after E256 (a registered pulse); `busy` is 0 in that same cycle.
- Latency: `result` is final and `done` is high exactly 256 cycles after the accept edge.
- Back-to-back: `start` is accepted in the same cycle that `done` is high, since the block is already in IDLE. The next `done` follows 256 cycles later.
- Reset mid-RUN: immediate return to IDLE with all registers at reset values; the partial result is discarded. The first `start` after deassertion is accepted normally.
- Arithmetic:
  - All lane arithmetic wraps mod 2^13.
  - The product uses the sign-extended 4-bit secret.
  - No saturation and no overflow flag.

## Test plan
- **Identity:** a0=1, all other a=0, s_k = k mod 15 − 7, `acc_clr`=1 → result_k = (s_k mod 8192), e.g. lane 0 = 8185. `done` comes exactly 256 cycles after `start`.
- **Negacyclic wrap:** a1=1, s0=3, s255=2, other coefficients 0 → result0 = 8190 (−2), result1 = 3, all other lanes 0.
- **Full-scale:** all a=8191, all s=1 → result_k = (254 − 2k) mod 8192, so result0 = 254, result127 = 0, result255 = 7936.
- **Accumulate:**
  - Run the identity test, then rerun with `acc_clr`=0 and the same inputs → every lane = 2·s_k mod 8192.
  - A third run with `acc_clr`=1 → values back to s_k.
- **Busy protection:** pulse `start` with different `a_poly` at cycles 10 and 200 of a run → both ignored. The result matches the single-run value and there is exactly one `done`.
- **Reset mid-run:** assert `rst` at cycle 100 → `busy`, `done` and `result` read 0 in the same cycle. A fresh `start` after reset produces the correct identity result 256 cycles later.
